// File: rtl/l2_pkg.sv
// Shared link-layer types: the ab record and the byte-receiver state encoding.
package l2_pkg;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } ab;

  typedef enum logic {WAIT_A, WAIT_B} ab_rx_state_e;

  localparam int AB_W = $bits(ab);

endpackage

// File: rtl/ab_byte_rx_if.sv
// Byte-in / record-out handshake bundle for ab_byte_rx.
interface ab_byte_rx_if;
  import l2_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_first;
  logic       out_valid;
  logic       out_ready;
  ab          out_ab;

  // Link driver and record consumer side
  modport master (
    output in_valid, in_data, in_first, out_ready,
    input  in_ready, out_valid, out_ab
  );

  // Receiver side
  modport slave (
    input  in_valid, in_data, in_first, out_ready,
    output in_ready, out_valid, out_ab
  );

endinterface

// File: rtl/ab_fifo.sv
// Small record FIFO holding completed ab records; DEPTH must be a power of 2.
module ab_fifo
  import l2_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  ab                din,
  input  logic             pop,
  output ab                dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  ab              mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_nxt;

  // Qualify requests so the FIFO can never overrun or underrun
  always_comb begin
    do_push   = push && !full;
    do_pop    = pop && !empty;
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Storage, pointers (wrap naturally at power-of-2 depth) and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/ab_byte_rx.sv
// Rebuilds ab records from an a-first byte stream and queues them for a consumer.
module ab_byte_rx
  import l2_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  ab_byte_rx_if.slave      bus,
  output logic [ERR_W-1:0] err_cnt,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  ab_rx_state_e     state;
  logic [7:0]       a_reg;
  logic             accept;
  logic             push;
  logic             pop;
  logic             err_inc;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  ab                push_rec;

  // Handshake qualification and framing-error detection
  always_comb begin
    accept   = bus.in_valid && bus.in_ready;
    pop      = bus.out_valid && bus.out_ready;
    push     = accept && (state == WAIT_B) && !bus.in_first;
    err_inc  = accept && (((state == WAIT_A) && !bus.in_first) ||
                          ((state == WAIT_B) &&  bus.in_first));
    push_rec = '{a: a_reg, b: bus.in_data};
  end

  // Framing FSM, held field a, busy flag and saturating error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WAIT_A;
      a_reg   <= '0;
      err_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      if (err_inc && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
      if (accept) begin
        case (state)
          WAIT_A: begin
            if (bus.in_first) begin
              a_reg <= bus.in_data;
              state <= WAIT_B;
              busy  <= 1'b1;
            end
          end
          WAIT_B: begin
            if (bus.in_first) begin
              a_reg <= bus.in_data;
            end else begin
              state <= WAIT_A;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= WAIT_A;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  ab_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_rec),
    .pop   (pop),
    .dout  (bus.out_ab),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // in_ready and out_valid derive only from registered occupancy
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;

  // Occupancy never exceeds the configured depth
  a_count_range: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));

endmodule

// File: doc/ab_byte_rx.md
# ab_byte_rx

Byte-stream receiver that rebuilds `l2_pkg::ab` records from a serial 8-bit link. Field `a` travels first and is marked by a first-byte flag; field `b` follows. Completed records are buffered in a small FIFO and presented on a valid/ready output. It is the receive end of the link whose transmit side packs `ab` records into byte pairs. It sits between the link byte interface and any consumer that takes `ab` directly on a port.

## Interface
- `DEPTH`, 2: output FIFO depth in records; power of 2, ≥ 2.
- `ERR_W`, 8: width of the saturating framing-error counter.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  byte present.
- `in_ready`  out  1  block accepts byte this cycle.
- `in_data`  in  8  byte payload.
- `in_first`  in  1  byte is field `a` (start of record).
- `out_valid`  out  1  head record valid.
- `out_ready`  in  1  consumer takes head record.
- `out_ab`  out  16  `l2_pkg::ab` head record (`a` = [15:8], `b` = [7:0]).
- `err_cnt`  out  ERR_W  framing errors, saturating.
- `busy`  out  1  high in WAIT_B (half record held).

## Operation
- Byte accepted when `in_valid && in_ready`. Record popped when `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`. It depends only on registered count: no combinational path from `out_ready`. When full, a pop and a push never occur in the same cycle.
- FSM states: `WAIT_A`, `WAIT_B`.
  - `WAIT_A`, accepted byte with `in_first=1`:
    - `a_reg <= in_data`.
    - Go to `WAIT_B`.
  - `WAIT_A`, accepted byte with `in_first=0`:
    - Byte dropped.
    - `err_cnt` +1.
    - Stay in `WAIT_A`.
  - `WAIT_B`, accepted byte with `in_first=0`:
    - Push `{a_reg, in_data}` into the FIFO.
    - Go to `WAIT_A`.
  - `WAIT_B`, accepted byte with `in_first=1`:
    - Resync: `err_cnt` +1.
    - `a_reg <= in_data`.
    - Stay in `WAIT_B`.
- `err_cnt` saturates at all-ones and never wraps.
- FIFO:
  - Pointers wrap modulo DEPTH.
  - `count` ranges 0..DEPTH.
  - A simultaneous push and pop leaves `count` unchanged.
  - Order is strictly preserved.
- `out_valid = (count != 0)`. `out_ab` = head entry; it holds stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - State `WAIT_A`.
  - `count=0`, `a_reg=0`, all FIFO entries 0.
  - `out_valid=0`, `out_ab=16'h0000`.
  - `err_cnt=0`, `busy=0`.
  - `in_ready=1`.
- Latency:
  - Field `b` accepted in cycle n → `out_valid=1` with the record in cycle n+1 (FIFO previously empty).
  - Pop in cycle n → next entry on `out_ab` in cycle n+1.
- Throughput: one record per two input cycles. The output side sustains one pop per cycle.
- Reset mid-record discards the held `a`: the FSM returns to `WAIT_A`. The next `in_first=0` byte counts as an error.
- The `err_cnt` increment registers in the same edge as the byte accept.

## Structure
- `l2_pkg` gains:
  - `typedef enum logic {WAIT_A, WAIT_B} ab_rx_state_e`.
  - `localparam int AB_W = $bits(ab)`.
- `ab` is reused unchanged from `l2_pkg`.
- One sub-module, `ab_fifo`:
  - Parameterised on DEPTH.
  - Stores `ab`.
  - Ports: push/pop/full/empty/count.
- The FSM, `a_reg` and the error counter live in `ab_byte_rx`.

## Test plan
- Basic record: bytes 0x01 (first=1), then 0x02 (first=0), `out_ready=1` → `out_ab=16'h0102` and `out_valid` for one cycle. This appears one cycle after the 0x02 accept. `err_cnt=0`.
- Back-pressure:
  - Stimulus: DEPTH=2, `out_ready=0`, send records {0x10,0x11}, {0x20,0x21}, {0x30,0x31}.
  - `in_ready` goes 0 after the second record is pushed, and the 0x30 byte stalls.
  - Raise `out_ready` → outputs 0x1011, 0x2021, 0x3031 in order, with no loss or duplication.
- Stray byte: 0x55 (first=0) in `WAIT_A` → no output, `err_cnt=1`, state stays `WAIT_A`.
- Resync: 0x11 f=1, 0x22 f=1, 0x33 f=0 → single output 16'h2233, `err_cnt=1`.
- Saturation: ERR_W=2, five stray bytes → `err_cnt=3`, holding at 3.
- Reset mid-record: accept 0x44 f=1, pulse `rst`, send 0x55 f=0 → no output, `err_cnt=1`, `busy=0`.
